// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// rtl/mor1kx_wb_arbiter_marocchino.sv - round-robin writeback-port arbiter with one-entry output stage
// Optional MOR1KX_WB_ARB_FIXED_PRIO_EN: fixed priority, lowest valid index wins.
module mor1kx_wb_arbiter_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_UNITS_LOG2       = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             pipeline_flush_i,
  input  logic                                             wb_stall_i,
  input  logic [(1<<NUM_UNITS_LOG2)-1:0]                   unit_valid_i,
  input  logic [(1<<NUM_UNITS_LOG2)*OPTION_OPERAND_WIDTH-1:0] unit_result_i,
  input  logic [(1<<NUM_UNITS_LOG2)*OPTION_RF_ADDR_WIDTH-1:0] unit_rfd_adr_i,
  input  logic [(1<<NUM_UNITS_LOG2)-1:0]                   unit_rf_wb_i,
  output logic [(1<<NUM_UNITS_LOG2)-1:0]                   unit_grant_o,
  output logic                                             wb_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]                  wb_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]                  wb_rfd_adr_o,
  output logic                                             wb_rf_wb_o,
  output logic [NUM_UNITS_LOG2-1:0]                        wb_unit_o
);

  localparam int NU = 1 << NUM_UNITS_LOG2;
  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int A  = OPTION_RF_ADDR_WIDTH;
  localparam int L  = NUM_UNITS_LOG2;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    result_q, result_d;
  logic [A-1:0]    adr_q, adr_d;
  logic            rf_wb_q, rf_wb_d;
  logic [L-1:0]    unit_q, unit_d;
  logic [L-1:0]    ptr;
  logic            accept;
  logic            grant_any;
  logic            grant_fire;
  logic [L-1:0]    grant_idx;
  logic [L-1:0]    scan_idx;

`ifdef MOR1KX_WB_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [L-1:0] ptr_q, ptr_d;

  assign ptr   = ptr_q;
  assign ptr_d = grant_fire ? grant_idx + 1'b1 : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign accept = ~pipeline_flush_i & (~wb_valid_o | ~wb_stall_i);

  // Scan upward from the pointer; index arithmetic wraps modulo NU by width.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < NU; i++) begin
      scan_idx = ptr + L'(i);
      if (!grant_any && unit_valid_i[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant_fire   = accept & grant_any;
  assign unit_grant_o = grant_fire ? (NU'(1) << grant_idx) : '0;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    adr_d    = adr_q;
    rf_wb_d  = rf_wb_q;
    unit_d   = unit_q;
    // Flush wins over stall and grant (grant_fire is already 0 during flush).
    if (pipeline_flush_i) begin
      state_d = EMPTY;
      rf_wb_d = 1'b0;
    end else if (grant_fire) begin
      state_d  = FULL;
      result_d = unit_result_i[grant_idx*W +: W];
      adr_d    = unit_rfd_adr_i[grant_idx*A +: A];
      rf_wb_d  = unit_rf_wb_i[grant_idx];
      unit_d   = grant_idx;
    end else if (state_q == FULL && !wb_stall_i) begin
      state_d = EMPTY;
      rf_wb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      result_q <= '0;
      adr_q    <= '0;
      rf_wb_q  <= 1'b0;
      unit_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      adr_q    <= adr_d;
      rf_wb_q  <= rf_wb_d;
      unit_q   <= unit_d;
    end
  end

  assign wb_valid_o   = (state_q == FULL);
  assign wb_result_o  = result_q;
  assign wb_rfd_adr_o = adr_q;
  assign wb_rf_wb_o   = rf_wb_q;
  assign wb_unit_o    = unit_q;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// tb/tb_mor1kx_wb_arbiter_marocchino.sv - self-checking bench for the writeback arbiter
module tb_mor1kx_wb_arbiter_marocchino;

  localparam int W = 32;
  localparam int A = 5;
  localparam int L = 2;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           stall = 1'b0;
  logic [N-1:0]   valid = '0;
  logic [N*W-1:0] result = '0;
  logic [N*A-1:0] adr = '0;
  logic [N-1:0]   rfwb = '0;
  logic [N-1:0]   grant;
  logic           wb_valid;
  logic [W-1:0]   wb_result;
  logic [A-1:0]   wb_adr;
  logic           wb_rfwb;
  logic [L-1:0]   wb_unit;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the output stage and arbitration pointer
  int           m_ptr = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_result = '0;
  logic [A-1:0] m_adr = '0;
  logic         m_rfwb = 1'b0;
  int           m_unit = 0;

  mor1kx_wb_arbiter_marocchino #(
    .OPTION_OPERAND_WIDTH(W), .OPTION_RF_ADDR_WIDTH(A), .NUM_UNITS_LOG2(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pipeline_flush_i(flush), .wb_stall_i(stall),
    .unit_valid_i(valid), .unit_result_i(result), .unit_rfd_adr_i(adr),
    .unit_rf_wb_i(rfwb), .unit_grant_o(grant), .wb_valid_o(wb_valid),
    .wb_result_o(wb_result), .wb_rfd_adr_o(wb_adr), .wb_rf_wb_o(wb_rfwb),
    .wb_unit_o(wb_unit)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (rst_n && !flush && !(m_valid && stall)) begin
      for (int i = 0; i < N; i++) begin
        if (g == '0 && valid[(m_ptr + i) % N]) g[(m_ptr + i) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_valid = 1'b0; m_result = '0; m_adr = '0; m_rfwb = 1'b0; m_unit = 0;
    end else begin
      logic [N-1:0] g;
      g = model_grant();
      if (flush) begin
        m_valid = 1'b0; m_rfwb = 1'b0;
      end else if (g != '0) begin
        for (int k = 0; k < N; k++) begin
          if (g[k]) begin
            m_valid = 1'b1; m_result = result[k*W +: W]; m_adr = adr[k*A +: A];
            m_rfwb = rfwb[k]; m_unit = k;
`ifndef MOR1KX_WB_ARB_FIXED_PRIO_EN
            m_ptr = (k + 1) % N;
`endif
          end
        end
      end else if (!stall) begin
        m_valid = 1'b0; m_rfwb = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_grant", 64'(grant), 64'(model_grant()));
      chk("model_wb_valid", 64'(wb_valid), 64'(m_valid));
      chk("model_wb_rf_wb", 64'(wb_rfwb), 64'(m_rfwb));
      chk("model_wb_result", 64'(wb_result), 64'(m_result));
      chk("model_wb_adr", 64'(wb_adr), 64'(m_adr));
      chk("model_wb_unit", 64'(wb_unit), 64'(m_unit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [W-1:0] r, input logic [A-1:0] a, input logic f);
    result[k*W +: W] = r;
    adr[k*A +: A]    = a;
    rfwb[k]          = f;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] exp_rr [4];
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b1000; exp_rr[3] = 4'b0001;

    // Reset state and idle
    rst_n = 1'b0;
    #2;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_wb_result", 64'(wb_result), 64'd0);
    chk("reset_wb_unit", 64'(wb_unit), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_grant", 64'(grant), 64'd0);
      chk("idle_wb_valid", 64'(wb_valid), 64'd0);
      tick();
    end

    // All units valid: rotation
    for (int k = 0; k < N; k++) set_unit(k, 32'h100 + k, A'(k + 1), 1'b1);
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", 64'(grant), 64'(4'b0001 << (i % 4)));
      if (i >= 1) chk("rr_wb_unit", 64'(wb_unit), 64'((i - 1) % 4));
      tick();
    end
    valid = '0;
    @(negedge clk);
    chk("rr_last_unit", 64'(wb_unit), 64'd0);
    tick();

    // Single unit 2 transfer
    set_unit(2, 32'hDEADBEEF, 5'd7, 1'b1);
    valid = 4'b0100;
    @(negedge clk);
    chk("u2_grant", 64'(grant), 64'(4'b0100));
    tick();
    valid = 4'b0010;
    set_unit(1, 32'hCAFE0001, 5'd9, 1'b0);
    stall = 1'b1;
    @(negedge clk);
    chk("u2_wb_valid", 64'(wb_valid), 64'd1);
    chk("u2_wb_result", 64'(wb_result), 64'hDEADBEEF);
    chk("u2_wb_adr", 64'(wb_adr), 64'd7);
    chk("u2_wb_rf_wb", 64'(wb_rfwb), 64'd1);
    chk("u2_wb_unit", 64'(wb_unit), 64'd2);
    chk("stall_grant", 64'(grant), 64'd0);

    // Stall holds the output stage
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("stall_grant", 64'(grant), 64'd0);
      chk("stall_result", 64'(wb_result), 64'hDEADBEEF);
      chk("stall_valid", 64'(wb_valid), 64'd1);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_grant", 64'(grant), 64'(4'b0010));
    tick();

    // Flush while FULL with unit 3 pending
    valid = 4'b1000;
    set_unit(3, 32'h33, 5'd3, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("u1_wb_result", 64'(wb_result), 64'hCAFE0001);
    chk("u1_wb_rf_wb", 64'(wb_rfwb), 64'd0);
    chk("u1_wb_valid", 64'(wb_valid), 64'd1);
    chk("flush_grant", 64'(grant), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flushed_valid", 64'(wb_valid), 64'd0);
    chk("flushed_rf_wb", 64'(wb_rfwb), 64'd0);
    chk("flushed_stale_result", 64'(wb_result), 64'hCAFE0001);
    chk("post_flush_grant", 64'(grant), 64'(4'b1000));
    tick();
    valid = '0;
    @(negedge clk);
    chk("u3_wb_unit", 64'(wb_unit), 64'd3);
    chk("u3_wb_result", 64'(wb_result), 64'h33);
    tick();

    // Pattern 1011: fixed priority vs round-robin (pointer is 0 here)
    valid = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef MOR1KX_WB_ARB_FIXED_PRIO_EN
      chk("fixed_grant", 64'(grant), 64'(4'b0001));
`else
      chk("rr1011_grant", 64'(grant), 64'(exp_rr[i]));
`endif
      tick();
    end

    // Reset mid-operation with a pending request
    valid = 4'b0100;
    set_unit(2, 32'h5A5A5A5A, 5'd17, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(wb_valid), 64'd0);
    chk("midreset_result", 64'(wb_result), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_grant", 64'(grant), 64'(4'b0100));
    tick();
    valid = '0;
    @(negedge clk);
    chk("postreset_result", 64'(wb_result), 64'h5A5A5A5A);
    chk("postreset_adr", 64'(wb_adr), 64'd17);

    // Mixed traffic checked against the model; units hold until granted
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      g = model_grant();
      tick();
      for (int k = 0; k < N; k++) begin
        if (g[k] || !valid[k]) begin
          valid[k] = 1'($urandom_range(0, 1));
          set_unit(k, $urandom, A'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
